// File: rtl/mm_bram_ctrl.sv
// Run controller and BRAM bridge for the Montgomery multiplier core.
// Optional run-cycle counter enabled by defining MM_BRAM_CYCLE_COUNT_EN.
module mm_bram_ctrl #(
    parameter int unsigned LIMB_WIDTH      = 17,
    parameter int unsigned BRAM_DATA_WIDTH = 32,
    parameter int unsigned CORE_ADDR_W     = 32,
    parameter logic [31:0] BASE_ADDR       = 32'h0,
    parameter int unsigned BRAM_LATENCY    = 1,
    parameter int unsigned OUT_REG         = 0,
    parameter int unsigned TIMEOUT_CYCLES  = 65535
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         start_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         timeout_o,
    output logic [31:0]                  cycles_o,
    output logic                         core_start_o,
    input  logic                         core_done_i,
    input  logic                         core_en_i,
    input  logic                         core_we_i,
    input  logic [CORE_ADDR_W-1:0]       core_addr_i,
    input  logic [LIMB_WIDTH-1:0]        core_din_i,
    output logic [LIMB_WIDTH-1:0]        core_dout_o,
    output logic                         core_rvalid_o,
    output logic [31:0]                  BRAM_addr_o,
    output logic [BRAM_DATA_WIDTH-1:0]   BRAM_din_o,
    input  logic [BRAM_DATA_WIDTH-1:0]   BRAM_dout_i,
    output logic [BRAM_DATA_WIDTH/8-1:0] BRAM_we_o,
    output logic                         BRAM_en_o,
    output logic                         BRAM_clock_o,
    output logic                         BRAM_reset_o
);

    localparam int unsigned BYTES      = BRAM_DATA_WIDTH / 8;
    localparam int unsigned BYTE_SHIFT = $clog2(BYTES);
    localparam int unsigned RV_DLY     = OUT_REG + BRAM_LATENCY;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic [31:0] wdog_q, wdog_d;

    logic        in_run;
    logic        launch_entry;
    logic        timeout_hit;

    assign in_run       = (state_q == S_RUN);
    assign launch_entry = ((state_q == S_IDLE) || (state_q == S_DONE)) && start_i;
    // wdog_q holds completed RUN cycles, so this fires on the TIMEOUT_CYCLES-th RUN cycle
    assign timeout_hit  = (TIMEOUT_CYCLES != 0) &&
                          (({1'b0, wdog_q} + 33'd1) == 33'(TIMEOUT_CYCLES));

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            wdog_q    <= '0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            wdog_q    <= wdog_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        wdog_d    = wdog_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (launch_entry) begin
                    state_d   = S_LAUNCH;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    wdog_d    = '0;
                end
            end
            S_LAUNCH: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (wdog_q != '1) begin
                    wdog_d = wdog_q + 32'd1;
                end
                if (core_done_i) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (timeout_hit) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o       = (state_q == S_LAUNCH) || in_run;
    assign core_start_o = (state_q == S_LAUNCH);
    assign done_o       = done_q;
    assign timeout_o    = timeout_q;

`ifdef MM_BRAM_CYCLE_COUNT_EN
    logic [31:0] cycles_q, cycles_d;

    always_comb begin
        cycles_d = cycles_q;
        if (launch_entry) begin
            cycles_d = '0;
        end else if (in_run && (cycles_q != '1)) begin
            cycles_d = cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign cycles_o = cycles_q;
`else
    assign cycles_o = '0;
`endif

    logic                       req_en;
    logic                       req_we_bit;
    logic [BYTES-1:0]           req_we;
    logic [31:0]                req_addr;
    logic [BRAM_DATA_WIDTH-1:0] req_din;
    logic                       rd_issue;

    assign req_en     = in_run && core_en_i;
    assign req_we_bit = req_en && core_we_i;
    assign req_we     = {BYTES{req_we_bit}};
    assign req_addr   = BASE_ADDR + (32'(core_addr_i) << BYTE_SHIFT);
    assign req_din    = BRAM_DATA_WIDTH'(core_din_i);
    assign rd_issue   = req_en && !core_we_i;

    if (OUT_REG != 0) begin : g_out_reg
        logic                       en_q;
        logic [BYTES-1:0]           we_q;
        logic [31:0]                addr_q;
        logic [BRAM_DATA_WIDTH-1:0] din_q;

        always_ff @(posedge clock_i) begin
            if (reset_i) begin
                en_q   <= 1'b0;
                we_q   <= '0;
                addr_q <= '0;
                din_q  <= '0;
            end else begin
                en_q   <= req_en;
                we_q   <= req_we;
                addr_q <= req_addr;
                din_q  <= req_din;
            end
        end

        assign BRAM_en_o   = en_q;
        assign BRAM_we_o   = we_q;
        assign BRAM_addr_o = addr_q;
        assign BRAM_din_o  = din_q;
    end else begin : g_out_comb
        assign BRAM_en_o   = req_en;
        assign BRAM_we_o   = req_we;
        assign BRAM_addr_o = req_addr;
        assign BRAM_din_o  = req_din;
    end

    // Read strobe pipeline spans the optional output register plus the BRAM latency
    logic [RV_DLY-1:0] rv_q, rv_d;

    always_comb begin
        rv_d = RV_DLY'({rv_q, rd_issue});
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rv_q <= '0;
        end else begin
            rv_q <= rv_d;
        end
    end

    assign core_rvalid_o = rv_q[RV_DLY-1];
    assign core_dout_o   = BRAM_dout_i[LIMB_WIDTH-1:0];
    assign BRAM_clock_o  = clock_i;
    assign BRAM_reset_o  = reset_i;

    logic unused_dout;
    assign unused_dout = ^BRAM_dout_i;

endmodule

// File: tb/tb_mm_bram_ctrl.sv
// Scoreboard bench for mm_bram_ctrl: two instances (combinational and registered
// request paths) share stimulus; a behavioural model queues per-cycle expectations.
module tb_mm_bram_ctrl;

    localparam logic [31:0] BASE0 = 32'h0000_0100;
    localparam logic [31:0] BASE1 = 32'hFFFF_FFF0;
    localparam int          TMO   = 50;

    localparam int P_IDLE   = 0;
    localparam int P_LAUNCH = 1;
    localparam int P_RUN    = 2;
    localparam int P_DONE   = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_i, start_i, core_done_i, core_en_i, core_we_i;
    logic [31:0] core_addr_i;
    logic [16:0] core_din_i;
    logic [31:0] BRAM_dout_i;

    logic        busy0, done0, tmo0, cstart0, rv0, en0, bclk0, brst0;
    logic [31:0] cyc0, addr0, din0;
    logic [16:0] dout0;
    logic [3:0]  we0;
    logic        busy1, done1, tmo1, cstart1, rv1, en1, bclk1, brst1;
    logic [31:0] cyc1, addr1, din1;
    logic [16:0] dout1;
    logic [3:0]  we1;

    mm_bram_ctrl #(
        .LIMB_WIDTH(17), .BRAM_DATA_WIDTH(32), .CORE_ADDR_W(32), .BASE_ADDR(BASE0),
        .BRAM_LATENCY(1), .OUT_REG(0), .TIMEOUT_CYCLES(TMO)
    ) u0 (
        .clock_i(clock), .reset_i(reset_i), .start_i(start_i),
        .busy_o(busy0), .done_o(done0), .timeout_o(tmo0), .cycles_o(cyc0),
        .core_start_o(cstart0), .core_done_i(core_done_i), .core_en_i(core_en_i),
        .core_we_i(core_we_i), .core_addr_i(core_addr_i), .core_din_i(core_din_i),
        .core_dout_o(dout0), .core_rvalid_o(rv0), .BRAM_addr_o(addr0), .BRAM_din_o(din0),
        .BRAM_dout_i(BRAM_dout_i), .BRAM_we_o(we0), .BRAM_en_o(en0),
        .BRAM_clock_o(bclk0), .BRAM_reset_o(brst0)
    );

    mm_bram_ctrl #(
        .LIMB_WIDTH(17), .BRAM_DATA_WIDTH(32), .CORE_ADDR_W(32), .BASE_ADDR(BASE1),
        .BRAM_LATENCY(2), .OUT_REG(1), .TIMEOUT_CYCLES(TMO)
    ) u1 (
        .clock_i(clock), .reset_i(reset_i), .start_i(start_i),
        .busy_o(busy1), .done_o(done1), .timeout_o(tmo1), .cycles_o(cyc1),
        .core_start_o(cstart1), .core_done_i(core_done_i), .core_en_i(core_en_i),
        .core_we_i(core_we_i), .core_addr_i(core_addr_i), .core_din_i(core_din_i),
        .core_dout_o(dout1), .core_rvalid_o(rv1), .BRAM_addr_o(addr1), .BRAM_din_o(din1),
        .BRAM_dout_i(BRAM_dout_i), .BRAM_we_o(we1), .BRAM_en_o(en1),
        .BRAM_clock_o(bclk1), .BRAM_reset_o(brst1)
    );

    typedef struct {
        logic        rst, busy, cstart, done, tmo;
        logic [31:0] cyc;
        logic        en0;
        logic [3:0]  we0;
        logic [31:0] addr0, din0;
        logic        en1;
        logic [3:0]  we1;
        logic [31:0] addr1, din1;
        logic        rv0, rv1;
        logic [16:0] dout;
    } exp_t;

    exp_t exp_q[$];

    int vectors = 0;
    int errors  = 0;
    int mon_cyc = 0;

    // behavioural model state
    int          m_phase;
    int          m_runs;
    logic        m_done, m_tmo;
    logic [31:0] m_cyc;
    logic        p1_en;
    logic [3:0]  p1_we;
    logic [31:0] p1_addr, p1_din;
    bit          hist[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, mon_cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_runs  = 0;
        m_done  = 1'b0;
        m_tmo   = 1'b0;
        m_cyc   = '0;
        p1_en   = 1'b0;
        p1_we   = '0;
        p1_addr = '0;
        p1_din  = '0;
        for (int i = 0; i < 3; i++) hist[i] = 1'b0;
    endtask

    task automatic step(input bit rst, input bit st, input bit cd);
        exp_t e;
        bit   run, issue;
        @(negedge clock);
        reset_i     = rst;
        start_i     = st;
        core_done_i = cd;
        core_en_i   = 1'($urandom_range(0, 1));
        core_we_i   = 1'($urandom_range(0, 1));
        core_addr_i = $urandom;
        core_din_i  = 17'($urandom);
        BRAM_dout_i = $urandom;

        run      = (m_phase == P_RUN);
        e.rst    = rst;
        e.busy   = (m_phase == P_LAUNCH) || run;
        e.cstart = (m_phase == P_LAUNCH);
        e.done   = m_done;
        e.tmo    = m_tmo;
`ifdef MM_BRAM_CYCLE_COUNT_EN
        e.cyc    = m_cyc;
`else
        e.cyc    = '0;
`endif
        e.en0    = run && core_en_i;
        e.we0    = (run && core_en_i && core_we_i) ? 4'hF : 4'h0;
        e.addr0  = BASE0 + core_addr_i * 32'd4;
        e.din0   = {15'd0, core_din_i};
        e.en1    = p1_en;
        e.we1    = p1_we;
        e.addr1  = p1_addr;
        e.din1   = p1_din;
        e.rv0    = hist[0];
        e.rv1    = hist[2];
        e.dout   = BRAM_dout_i[16:0];
        exp_q.push_back(e);

        issue = run && core_en_i && !core_we_i;
        if (rst) begin
            model_reset();
        end else begin
            p1_en   = e.en0;
            p1_we   = e.we0;
            p1_addr = BASE1 + core_addr_i * 32'd4;
            p1_din  = e.din0;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = issue;
            case (m_phase)
                P_IDLE, P_DONE: if (st) begin
                    m_phase = P_LAUNCH;
                    m_done  = 1'b0;
                    m_tmo   = 1'b0;
                    m_cyc   = '0;
                    m_runs  = 0;
                end
                P_LAUNCH: m_phase = P_RUN;
                default: begin
                    m_runs = m_runs + 1;
                    if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 32'd1;
                    if (cd) begin
                        m_phase = P_DONE;
                        m_done  = 1'b1;
                    end else if (m_runs == TMO) begin
                        m_phase = P_DONE;
                        m_done  = 1'b1;
                        m_tmo   = 1'b1;
                    end
                end
            endcase
        end
    endtask

    exp_t me;
    always @(negedge clock) begin
        #1;
        if (exp_q.size() != 0) begin
            me = exp_q.pop_front();
            mon_cyc++;
            chk("bram_reset0", 32'(brst0), 32'(me.rst));
            chk("bram_reset1", 32'(brst1), 32'(me.rst));
            chk("bram_clock0", 32'(bclk0), 32'(clock));
            chk("busy0", 32'(busy0), 32'(me.busy));
            chk("busy1", 32'(busy1), 32'(me.busy));
            chk("core_start0", 32'(cstart0), 32'(me.cstart));
            chk("core_start1", 32'(cstart1), 32'(me.cstart));
            chk("done0", 32'(done0), 32'(me.done));
            chk("done1", 32'(done1), 32'(me.done));
            chk("timeout0", 32'(tmo0), 32'(me.tmo));
            chk("timeout1", 32'(tmo1), 32'(me.tmo));
            chk("cycles0", cyc0, me.cyc);
            chk("cycles1", cyc1, me.cyc);
            chk("en0", 32'(en0), 32'(me.en0));
            chk("we0", 32'(we0), 32'(me.we0));
            chk("addr0", addr0, me.addr0);
            chk("din0", din0, me.din0);
            chk("en1", 32'(en1), 32'(me.en1));
            chk("we1", 32'(we1), 32'(me.we1));
            chk("addr1", addr1, me.addr1);
            chk("din1", din1, me.din1);
            chk("rvalid0", 32'(rv0), 32'(me.rv0));
            chk("rvalid1", 32'(rv1), 32'(me.rv1));
            chk("dout0", 32'(dout0), 32'(me.dout));
            chk("dout1", 32'(dout1), 32'(me.dout));
        end
    end

    task automatic bound_fail(input string name);
        errors++;
        $display("FAIL %s cycle budget expired got=phase%0d expected=target", name, m_phase);
    endtask

    initial begin
        int guard;
        reset_i     = 1'b1;
        start_i     = 1'b0;
        core_done_i = 1'b0;
        core_en_i   = 1'b0;
        core_we_i   = 1'b0;
        core_addr_i = '0;
        core_din_i  = '0;
        BRAM_dout_i = '0;
        model_reset();
        repeat (3) @(posedge clock);

        // run ending by core_done on RUN cycle 40, with start_i noise while busy
        step(0, 0, 0);
        step(0, 1, 0);
        guard = 0;
        while (!(m_phase == P_RUN && m_runs == 39) && guard < 100) begin
            step(0, 1'($urandom_range(0, 1)), 0);
            guard++;
        end
        if (guard >= 100) bound_fail("run40");
        step(0, 0, 1);
        repeat (3) step(0, 0, 0);

        // run ending by watchdog
        step(0, 1, 0);
        guard = 0;
        while (m_phase != P_DONE && guard < 200) begin
            step(0, 0, 0);
            guard++;
        end
        if (guard >= 200) bound_fail("watchdog");
        repeat (2) step(0, 0, 0);

        // restart clears timeout, then reset on RUN cycle 7
        step(0, 1, 0);
        guard = 0;
        while (!(m_phase == P_RUN && m_runs == 6) && guard < 100) begin
            step(0, 0, 0);
            guard++;
        end
        if (guard >= 100) bound_fail("reset_mid_run");
        step(1, 0, 0);
        repeat (6) step(0, 0, 1'($urandom_range(0, 1)));

        repeat (1500)
            step($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0);

        repeat (2) @(negedge clock);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
